// File: rtl/bit_permuter_if.sv
// Stream bundle for bit_permuter: an input word channel and an output word channel,
// each with valid/ready. The slave modport is the permuter's view.
interface bit_permuter_if #(
    parameter int WIDTH = 256
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/bit_permuter.sv
// Runtime-reprogrammable bit permuter with an LFSR-driven Fisher-Yates table generator.
// Optional inverse mapping (receiver-side descrambler) enabled by BIT_PERMUTER_INV_EN.
module bit_permuter #(
    parameter  int WIDTH = 256,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    bit_permuter_if.slave    s,
    input  logic             regen,
    input  logic [15:0]      seed,
    output logic             busy,
    output logic             done,
    input  logic [IDX_W-1:0] tbl_raddr,
`ifdef BIT_PERMUTER_INV_EN
    input  logic             inv,
`endif
    output logic [IDX_W-1:0] tbl_rdata
);

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_INIT = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_SHUF,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [15:0]      r_lfsr;
    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_perm [WIDTH];
    logic             r_busy;
    logic             r_done;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic [15:0]      w_lfsr_next;
    logic [IDX_W-1:0] w_mask;
    logic [IDX_W-1:0] w_j;
    logic             w_accept;
    logic             w_in_ready;
    logic             w_xfer;
    logic [WIDTH-1:0] w_fwd;
    logic [WIDTH-1:0] w_word;

    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);

    // Smear the highest set bit of i downward: smallest 2^n-1 covering i.
    always_comb begin
        w_mask = r_i;
        for (int unsigned sh = 1; sh < IDX_W; sh++) begin
            w_mask = w_mask | (r_i >> sh);
        end
    end

    assign w_j      = r_lfsr[IDX_W-1:0] & w_mask;
    assign w_accept = (w_j <= r_i);

    assign w_in_ready = !r_busy && (!r_out_valid || s.out_ready);
    assign w_xfer     = s.in_valid && w_in_ready;

    always_comb begin
        w_fwd = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            w_fwd[k] = s.in_data[r_perm[k]];
        end
    end

`ifdef BIT_PERMUTER_INV_EN
    logic [WIDTH-1:0] w_inv;

    always_comb begin
        w_inv = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            w_inv[r_perm[k]] = s.in_data[k];
        end
    end

    assign w_word = inv ? w_inv : w_fwd;
`else
    assign w_word = w_fwd;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lfsr      <= LFSR_INIT;
            r_i         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int unsigned k = 0; k < WIDTH; k++) begin
                r_perm[k] <= IDX_W'(k);
            end
        end else begin
            if (w_xfer) begin
                r_out_data  <= w_word;
                r_out_valid <= 1'b1;
            end else if (s.out_ready) begin
                r_out_valid <= 1'b0;
            end

            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // Seed is loaded here rather than in INIT; the LFSR is idle until SHUF.
                    if (regen) begin
                        r_state <= S_INIT;
                        r_busy  <= 1'b1;
                        r_lfsr  <= (seed == 16'h0000) ? LFSR_INIT : seed;
                    end
                end
                S_INIT: begin
                    for (int unsigned k = 0; k < WIDTH; k++) begin
                        r_perm[k] <= IDX_W'(k);
                    end
                    r_i     <= IDX_W'(WIDTH - 1);
                    r_state <= S_SHUF;
                end
                S_SHUF: begin
                    r_lfsr <= w_lfsr_next;
                    if (w_accept) begin
                        r_perm[r_i] <= r_perm[w_j];
                        r_perm[w_j] <= r_perm[r_i];
                        r_i         <= r_i - 1'b1;
                        if (r_i == IDX_W'(1)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s.in_ready  = w_in_ready;
    assign s.out_valid = r_out_valid;
    assign s.out_data  = r_out_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign tbl_rdata   = r_perm[tbl_raddr];

endmodule

// File: tb/tb_bit_permuter.sv
// Directed bench for bit_permuter at WIDTH=8: vector tables for the datapath plus
// hand-written sequences for generation, backpressure, ignored regen and mid-run reset.
module tb_bit_permuter;

    localparam int W  = 8;
    localparam int IW = 3;

    typedef logic [IW-1:0] perm_t [W];
    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] dout;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          regen;
    logic [15:0]   seed;
    logic          busy;
    logic          done;
    logic [IW-1:0] raddr;
    logic [IW-1:0] rdata;
`ifdef BIT_PERMUTER_INV_EN
    logic          inv;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_permuter_if #(.WIDTH(W)) u_if ();

    bit_permuter #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (u_if),
        .regen     (regen),
        .seed      (seed),
        .busy      (busy),
        .done      (done),
        .tbl_raddr (raddr),
`ifdef BIT_PERMUTER_INV_EN
        .inv       (inv),
`endif
        .tbl_rdata (rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference Fisher-Yates generator with the 16-bit Galois LFSR.
    function automatic void model(input logic [15:0] sd, output perm_t p);
        logic [15:0]   l;
        logic [IW-1:0] t;
        int            i;
        int            m;
        int            j;
        l = (sd == 16'h0000) ? 16'hACE1 : sd;
        for (int k = 0; k < W; k++) p[k] = IW'(k);
        i = W - 1;
        while (i >= 1) begin
            m = 1;
            while (m < i) m = m * 2 + 1;
            j = int'(l[IW-1:0]) & m;
            if (j <= i) begin
                t    = p[i];
                p[i] = p[j];
                p[j] = t;
                i--;
            end
            l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
        end
    endfunction

    function automatic logic [W-1:0] fwd(input perm_t p, input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) r[k] = d[p[k]];
        return r;
    endfunction

    task automatic check_table(input string name, input perm_t p);
        for (int a = 0; a < W; a++) begin
            raddr = IW'(a);
            #1;
            chk(name, 32'(rdata), 32'(p[a]));
        end
    endtask

    task automatic push(input string name, input logic [W-1:0] d, input logic [W-1:0] exp);
        u_if.in_valid = 1'b1;
        u_if.in_data  = d;
        chk({name, "_in_ready"}, 32'(u_if.in_ready), 32'd1);
        tick();
        u_if.in_valid = 1'b0;
        chk({name, "_out_valid"}, 32'(u_if.out_valid), 32'd1);
        chk({name, "_out_data"}, 32'(u_if.out_data), 32'(exp));
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 500) begin
            tick();
            edges++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        perm_t ident;
        perm_t hand;
        perm_t p;
        vec_t  vid [4];
        vec_t  vfw [6];
        int    edges;
        int    npulse;

        for (int k = 0; k < W; k++) ident[k] = IW'(k);
        // Hand-traced ACE1 shuffle: 7 swaps, 2 rejections (i=2 twice).
        hand = '{3'd3, 3'd5, 3'd7, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1};
        vid = '{'{8'hA5, 8'hA5}, '{8'h3C, 8'h3C}, '{8'h00, 8'h00}, '{8'hFF, 8'hFF}};
        vfw = '{'{8'h01, 8'h40}, '{8'hA5, 8'h4E}, '{8'h0F, 8'hC9},
                '{8'h80, 8'h04}, '{8'h02, 8'h80}, '{8'hFF, 8'hFF}};

        rst_n          = 1'b0;
        regen          = 1'b0;
        seed           = 16'h0000;
        raddr          = '0;
        u_if.in_valid  = 1'b0;
        u_if.in_data   = '0;
        u_if.out_ready = 1'b1;
`ifdef BIT_PERMUTER_INV_EN
        inv            = 1'b0;
`endif
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(u_if.in_ready), 32'd1);
        chk("rst_out_valid", 32'(u_if.out_valid), 32'd0);
        chk("rst_out_data", 32'(u_if.out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        check_table("rst_table", ident);

        for (int v = 0; v < 4; v++) push("ident_vec", vid[v].din, vid[v].dout);
        tick();
        chk("drain_out_valid", 32'(u_if.out_valid), 32'd0);

        // Seed 0 falls back to ACE1.
        seed  = 16'h0000;
        regen = 1'b1;
        tick();
        regen = 1'b0;
        chk("gen_busy_rise", 32'(busy), 32'd1);
        chk("gen_in_ready_busy", 32'(u_if.in_ready), 32'd0);
        wait_done(edges);
        chk("gen_latency", 32'(edges), 32'd10);
        chk("gen_busy_at_done", 32'(busy), 32'd1);
        tick();
        chk("gen_done_single", 32'(done), 32'd0);
        chk("gen_busy_fall", 32'(busy), 32'd0);
        check_table("gen_table", hand);

        for (int v = 0; v < 6; v++) push("fwd_vec", vfw[v].din, vfw[v].dout);
        tick();

        u_if.out_ready = 1'b0;
        u_if.in_valid  = 1'b1;
        u_if.in_data   = 8'h11;
        tick();
        u_if.in_data = 8'h22;
        #1;
        chk("bp_in_ready_low", 32'(u_if.in_ready), 32'd0);
        tick();
        chk("bp_hold_valid", 32'(u_if.out_valid), 32'd1);
        chk("bp_hold_data", 32'(u_if.out_data), 32'(fwd(hand, 8'h11)));
        u_if.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", 32'(u_if.in_ready), 32'd1);
        tick();
        u_if.in_valid = 1'b0;
        chk("bp_second_data", 32'(u_if.out_data), 32'(fwd(hand, 8'h22)));
        chk("bp_second_valid", 32'(u_if.out_valid), 32'd1);
        tick();
        chk("bp_drained", 32'(u_if.out_valid), 32'd0);

        // Word and regen together: word uses the old table, second regen ignored.
        u_if.in_valid = 1'b1;
        u_if.in_data  = 8'h0F;
        seed          = 16'h5555;
        regen         = 1'b1;
        tick();
        u_if.in_valid = 1'b0;
        chk("simul_old_table", 32'(u_if.out_data), 32'hC9);
        chk("simul_busy", 32'(busy), 32'd1);
        seed = 16'h9999;
        tick();
        regen  = 1'b0;
        npulse = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (done) npulse++;
        end
        chk("ignore_done_count", 32'(npulse), 32'd1);
        chk("ignore_busy", 32'(busy), 32'd0);
        model(16'h5555, p);
        check_table("ignore_table", p);

        u_if.out_ready = 1'b0;
        u_if.in_valid  = 1'b1;
        u_if.in_data   = 8'h33;
        tick();
        u_if.in_valid = 1'b0;
        seed          = 16'h1111;
        regen         = 1'b1;
        tick();
        regen = 1'b0;
        tick();
        repeat (5) tick();
        chk("midrst_busy_before", 32'(busy), 32'd1);
        chk("midrst_held_data", 32'(u_if.out_data), 32'(fwd(p, 8'h33)));
        rst_n = 1'b0;
        tick();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out_valid", 32'(u_if.out_valid), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        check_table("midrst_table", ident);
        rst_n          = 1'b1;
        u_if.out_ready = 1'b1;
        tick();

        seed  = 16'h1234;
        regen = 1'b1;
        tick();
        regen = 1'b0;
        wait_done(edges);
        tick();
        model(16'h1234, p);
        check_table("s1234_table", p);

`ifdef BIT_PERMUTER_INV_EN
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] w;
            logic [W-1:0] y;
            w             = W'($urandom);
            u_if.in_valid = 1'b1;
            u_if.in_data  = w;
            inv           = 1'b0;
            tick();
            y = u_if.out_data;
            chk("inv_fwd", 32'(y), 32'(fwd(p, w)));
            u_if.in_data = y;
            inv          = 1'b1;
            tick();
            chk("inv_roundtrip", 32'(u_if.out_data), 32'(w));
        end
        u_if.in_valid = 1'b0;
        inv           = 1'b0;
`else
        push("s1234_fwd", 8'h5A, fwd(p, 8'h5A));
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
